riscv_test_monitor: RTL and testbench

- Synthesizable pass/fail monitor for riscv-tests style programs; replaces hard-wired hierarchical probing of x3/x26/x27 in benches.
- Snoops the core's register-file write-back port and keeps shadow copies of three configurable architectural registers.
- Runs a settle/verdict/timeout state machine and drives sticky pass/fail/timeout status for bench or SoC status logic.
- Sits beside `top`, tapped onto the regs write port.

---
 rtl/test_mon_pkg.sv | 29 ++
 rtl/test_mon_shadow.sv | 43 ++++
 rtl/riscv_test_monitor.sv | 119 +++++++++++
 tb/tb_riscv_test_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/test_mon_pkg.sv
// Shared types and defaults for the riscv-tests pass/fail monitor.
// Slot numbers give each watched register a fixed position in the shadow array.
package test_mon_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mon_state_e;

    localparam int DEFAULT_TESTNUM_REG = 3;
    localparam int DEFAULT_DONE_REG    = 26;
    localparam int DEFAULT_RESULT_REG  = 27;
    localparam int DEFAULT_DONE_VALUE  = 1;
    localparam int DEFAULT_PASS_VALUE  = 1;

    localparam int NUM_WATCH    = 3;
    localparam int SLOT_DONE    = 0;
    localparam int SLOT_RESULT  = 1;
    localparam int SLOT_TESTNUM = 2;

    // RUN and SETTLE are the only states in which the monitor still observes the core.
    function automatic logic is_live(mon_state_e s);
        return (s == ST_RUN) || (s == ST_SETTLE);
    endfunction

endpackage

// File: rtl/test_mon_shadow.sv
// Snoops the register-file write port and keeps shadow copies of the watched registers.
// Writes to x0 never land, even if a watched index is configured as 0.
module test_mon_shadow
    import test_mon_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int DONE_REG    = DEFAULT_DONE_REG,
    parameter int RESULT_REG  = DEFAULT_RESULT_REG,
    parameter int TESTNUM_REG = DEFAULT_TESTNUM_REG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] shadow [NUM_WATCH]
);

    localparam logic [ADDR_WIDTH-1:0] DONE_IDX    = ADDR_WIDTH'(DONE_REG);
    localparam logic [ADDR_WIDTH-1:0] RESULT_IDX  = ADDR_WIDTH'(RESULT_REG);
    localparam logic [ADDR_WIDTH-1:0] TESTNUM_IDX = ADDR_WIDTH'(TESTNUM_REG);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WATCH; i++) begin
                shadow[i] <= '0;
            end
        end else if (en && we && (waddr != '0)) begin
            if (waddr == DONE_IDX) begin
                shadow[SLOT_DONE] <= wdata;
            end
            if (waddr == RESULT_IDX) begin
                shadow[SLOT_RESULT] <= wdata;
            end
            if (waddr == TESTNUM_IDX) begin
                shadow[SLOT_TESTNUM] <= wdata;
            end
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for riscv-tests programs: settle/verdict/timeout FSM driving
// sticky status flags from shadows of the done, result and test-number registers.
module riscv_test_monitor
    import test_mon_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 5,
    parameter int                    DONE_REG       = DEFAULT_DONE_REG,
    parameter int                    RESULT_REG     = DEFAULT_RESULT_REG,
    parameter int                    TESTNUM_REG    = DEFAULT_TESTNUM_REG,
    parameter logic [DATA_WIDTH-1:0] DONE_VALUE     = DATA_WIDTH'(DEFAULT_DONE_VALUE),
    parameter logic [DATA_WIDTH-1:0] PASS_VALUE     = DATA_WIDTH'(DEFAULT_PASS_VALUE),
    parameter int unsigned           SETTLE_CYCLES  = 20,
    parameter int unsigned           TIMEOUT_CYCLES = 100000,
    parameter int                    CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic                  timeout_o,
    output logic [DATA_WIDTH-1:0] testnum_o,
    output logic [CNT_WIDTH-1:0]  cycle_cnt_o
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0]   SETTLE_LOAD  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] DONE_IDX     = ADDR_WIDTH'(DONE_REG);

    mon_state_e            state;
    mon_state_e            state_next;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [CNT_WIDTH-1:0]  cycle_cnt;
    logic [DATA_WIDTH-1:0] shadow [NUM_WATCH];
    logic                  live;
    logic                  done_hit;
    logic                  timeout_hit;

    assign live        = is_live(state);
    assign done_hit    = we_i && (waddr_i == DONE_IDX) && (wdata_i == DONE_VALUE);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt == TIMEOUT_LAST);
    assign cycle_cnt_o = cycle_cnt;

    test_mon_shadow #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DONE_REG    (DONE_REG),
        .RESULT_REG  (RESULT_REG),
        .TESTNUM_REG (TESTNUM_REG)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .en     (live),
        .we     (we_i),
        .waddr  (waddr_i),
        .wdata  (wdata_i),
        .shadow (shadow)
    );

    // A done write beats a simultaneous timeout; the verdict reads the registered
    // result shadow, so a write in the final settle cycle is not seen.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (done_hit) begin
                    state_next = ST_SETTLE;
                end else if (timeout_hit) begin
                    state_next = ST_TIMEOUT;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = (shadow[SLOT_RESULT] == PASS_VALUE) ? ST_PASS : ST_FAIL;
                end
            end
            default: state_next = state;
        endcase
    end

    // The cycle counter stops on the edge that enters a terminal state, so it
    // reports the index of the last live cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            settle_cnt <= '0;
            cycle_cnt  <= '0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            timeout_o  <= 1'b0;
            testnum_o  <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_RUN) && (state_next == ST_SETTLE)) begin
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (is_live(state_next) && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if ((state == ST_SETTLE) && (state_next != ST_SETTLE)) begin
                testnum_o <= shadow[SLOT_TESTNUM];
            end
            done_o    <= !is_live(state_next);
            pass_o    <= (state_next == ST_PASS);
            fail_o    <= (state_next == ST_FAIL);
            timeout_o <= (state_next == ST_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: directed riscv-tests scenarios plus random write
// streams, each compared cycle by cycle against a verdict computed from the rules.
module tb_riscv_test_monitor;

    localparam int SETTLE  = 20;
    localparam int TIMEOUT = 100;
    localparam int NCYC    = 125;
    localparam int K_PASS  = 0;
    localparam int K_FAIL  = 1;
    localparam int K_TO    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        done_o;
    logic        pass_o;
    logic        fail_o;
    logic        timeout_o;
    logic [31:0] testnum_o;
    logic [31:0] cycle_cnt_o;

    logic        s_we   [NCYC];
    logic [4:0]  s_addr [NCYC];
    logic [31:0] s_data [NCYC];

    int          compared = 0;
    int          mismatched = 0;
    int          exp_final;
    int          exp_kind;
    logic [31:0] exp_tn;

    always #5 clk = ~clk;

    riscv_test_monitor #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .timeout_o   (timeout_o),
        .testnum_o   (testnum_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int k);
        we_i    = s_we[k];
        waddr_i = s_addr[k];
        wdata_i = s_data[k];
    endtask

    task automatic clearStim();
        for (int k = 0; k < NCYC; k++) begin
            s_we[k]   = 1'b0;
            s_addr[k] = 5'($urandom);
            s_data[k] = $urandom;
        end
    endtask

    task automatic putWrite(input int k, input int a, input logic [31:0] d, input logic en = 1'b1);
        s_we[k]   = en;
        s_addr[k] = 5'(a);
        s_data[k] = d;
    endtask

    // Reference: find the first qualifying done write within the timeout window,
    // then replay every landed write before the verdict cycle.
    task automatic computeModel();
        int          d;
        logic [31:0] result;
        d = -1;
        for (int k = 0; k < TIMEOUT && d < 0; k++) begin
            if (s_we[k] && s_addr[k] == 5'd26 && s_data[k] == 32'd1) d = k;
        end
        exp_tn = 32'd0;
        if (d < 0) begin
            exp_final = TIMEOUT - 1;
            exp_kind  = K_TO;
        end else begin
            exp_final = d + SETTLE;
            result    = 32'd0;
            for (int k = 0; k < exp_final; k++) begin
                if (s_we[k] && s_addr[k] == 5'd27) result = s_data[k];
                if (s_we[k] && s_addr[k] == 5'd3)  exp_tn = s_data[k];
            end
            exp_kind = (result == 32'd1) ? K_PASS : K_FAIL;
        end
    endtask

    task automatic checkCycle(input string name, input int k);
        logic over;
        over = (k > exp_final);
        checkOutput({name, ".cnt"},     cycle_cnt_o, over ? 32'(exp_final) : 32'(k));
        checkOutput({name, ".done"},    32'(done_o),    32'(over));
        checkOutput({name, ".pass"},    32'(pass_o),    32'(over && exp_kind == K_PASS));
        checkOutput({name, ".fail"},    32'(fail_o),    32'(over && exp_kind == K_FAIL));
        checkOutput({name, ".timeout"}, 32'(timeout_o), 32'(over && exp_kind == K_TO));
        checkOutput({name, ".testnum"}, testnum_o,      over ? exp_tn : 32'd0);
    endtask

    task automatic doReset();
        rst  = 1'b1;
        we_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic runTest(input string name, input int ncyc);
        computeModel();
        for (int k = 0; k < ncyc; k++) begin
            checkCycle(name, k);
            applyStimulus(k);
            @(negedge clk);
        end
        we_i = 1'b0;
    endtask

    task automatic passStim();
        clearStim();
        putWrite(10, 3, 32'd5);
        putWrite(20, 27, 32'd1);
        putWrite(50, 26, 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        we_i    = 1'b0;
        waddr_i = '0;
        wdata_i = '0;
        @(negedge clk);
        doReset();

        passStim();
        runTest("pass", NCYC);
        doReset();

        clearStim();
        putWrite(8, 3, 32'd7);
        putWrite(15, 27, 32'd0);
        putWrite(30, 26, 32'd1);
        runTest("fail", NCYC);
        doReset();

        clearStim();
        putWrite(5, 27, 32'd0);
        putWrite(40, 26, 32'd1);
        putWrite(50, 27, 32'd1);
        runTest("late_ok", NCYC);
        doReset();

        clearStim();
        putWrite(5, 27, 32'd0);
        putWrite(40, 26, 32'd1);
        putWrite(60, 27, 32'd1);
        runTest("late_final", NCYC);
        doReset();

        clearStim();
        runTest("timeout", NCYC);
        doReset();

        clearStim();
        putWrite(60, 27, 32'd1);
        putWrite(99, 26, 32'd1);
        runTest("done_at_expiry", NCYC);
        doReset();

        clearStim();
        putWrite(10, 26, 32'd2);
        putWrite(12, 0, 32'd1);
        putWrite(14, 27, 32'd1, 1'b0);
        putWrite(16, 3, 32'd9, 1'b0);
        putWrite(30, 26, 32'd1);
        runTest("filters", NCYC);
        doReset();

        passStim();
        runTest("mid_settle", 60);
        doReset();
        passStim();
        putWrite(10, 3, 32'd11);
        runTest("after_mid_reset", NCYC);
        doReset();
        clearStim();
        putWrite(3, 3, 32'd2);
        putWrite(4, 27, 32'd3);
        putWrite(25, 26, 32'd1);
        runTest("after_pass_reset", NCYC);
        doReset();

        for (int t = 0; t < 25; t++) begin
            int d;
            clearStim();
            for (int k = 0; k < NCYC; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 4))
                        0:       s_addr[k] = 5'd0;
                        1:       s_addr[k] = 5'd3;
                        2:       s_addr[k] = 5'd26;
                        3:       s_addr[k] = 5'd27;
                        default: s_addr[k] = 5'($urandom);
                    endcase
                    s_we[k]   = ($urandom_range(0, 4) != 0);
                    s_data[k] = ($urandom_range(0, 2) == 2) ? $urandom : 32'($urandom_range(0, 2));
                end
            end
            d = $urandom_range(0, 115);
            if (d < TIMEOUT) putWrite(d, 26, 32'd1);
            runTest($sformatf("rand%0d", t), NCYC);
            doReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
